// File: rtl/hba_pkg.sv
// Shared definitions for the HBA bus controller: FSM encoding, default sizing and
// the master-index type.
package hba_pkg;

  localparam int unsigned HbaNumMasters    = 4;
  localparam int unsigned HbaAddrWidth     = 12;
  localparam int unsigned HbaTimeoutCycles = 255;
  localparam int unsigned HbaCntWidth      = 8;

  // Width of a master index; the bus tops out at four requesters.
  localparam int unsigned HbaMidxW = 2;

  typedef logic [HbaMidxW-1:0] hba_midx_t;

  typedef enum logic [1:0] {
    StIdle,
    StOwned,
    StXfer
  } hba_state_e;

endpackage

// File: rtl/hba_rr_pick.sv
// Combinational round-robin picker: scans requesters starting just after the last
// winner, wrapping around, and returns the first hit as one-hot plus index.
module hba_rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  always_comb begin
    int unsigned   cand;
    logic [IW-1:0] cand_idx;
    logic          found;
    gnt_o    = '0;
    idx_o    = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    // last_i itself is scanned last, so a lone requester can win twice in a row.
    for (int unsigned i = 1; i <= N; i++) begin
      cand = 32'(last_i) + i;
      if (cand >= N) begin
        cand = cand - N;
      end
      cand_idx = IW'(cand);
      if (!found && req_i[cand_idx]) begin
        found           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/hba_bus_ctrl.sv
// HBA bus controller: round-robin ownership among up to four masters, with a
// per-transfer watchdog that fakes an acknowledge and logs the first failing access.
module hba_bus_ctrl
  import hba_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = HbaNumMasters,
  parameter int unsigned ADDR_WIDTH     = HbaAddrWidth,
  parameter int unsigned TIMEOUT_CYCLES = HbaTimeoutCycles,
  parameter int unsigned CNT_WIDTH      = HbaCntWidth
) (
  input  logic                  hba_clk,
  input  logic                  hba_reset_n,
  input  logic [3:0]            hba_mrequest,
  input  logic                  hba_select,
  input  logic                  hba_xferack,
  input  logic [ADDR_WIDTH-1:0] hba_abus,
  output logic [3:0]            hba_mgrant,
  output logic                  hba_xferack_timeout,
  output logic                  err_valid,
  output logic                  err_overflow,
  output logic [1:0]            err_master,
  output logic [ADDR_WIDTH-1:0] err_addr,
  input  logic                  err_clear
);

  localparam bit WdEnable = TIMEOUT_CYCLES != 0;
  localparam logic [CNT_WIDTH-1:0] CntLast =
      CNT_WIDTH'(WdEnable ? TIMEOUT_CYCLES - 1 : 0);
  localparam hba_midx_t LastReset = hba_midx_t'(NUM_MASTERS - 1);

  hba_state_e state_q, state_d;

  logic [3:0]            grant_q, grant_d;
  hba_midx_t             owner_q, owner_d;
  hba_midx_t             last_q, last_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic                  timeout_q, timeout_d;
  logic                  err_valid_q, err_valid_d;
  logic                  err_overflow_q, err_overflow_d;
  hba_midx_t             err_master_q, err_master_d;
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;

  logic [NUM_MASTERS-1:0] pick_gnt;
  hba_midx_t              pick_idx;
  logic                   pick_valid;
  logic                   owner_req;
  logic                   expire;
  logic                   owner_release;

  // Slicing to NUM_MASTERS keeps requests from unpopulated slots out of arbitration.
  hba_rr_pick #(
    .N  (NUM_MASTERS),
    .IW (HbaMidxW)
  ) u_pick (
    .req_i   (hba_mrequest[NUM_MASTERS-1:0]),
    .last_i  (last_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  assign owner_req     = hba_mrequest[owner_q];
  assign owner_release = (state_q == StOwned) && !hba_select && !owner_req;

  // A real acknowledge in the expiry cycle always beats the watchdog.
  assign expire = WdEnable && (state_q == StXfer) && !hba_xferack && (cnt_q == CntLast);

  // FSM state register.
  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StOwned;
        end
      end
      StOwned: begin
        if (hba_select) begin
          state_d = StXfer;
        end else if (!owner_req) begin
          state_d = StIdle;
        end
      end
      StXfer: begin
        // Ack, watchdog expiry and master abort all hand the bus back to the owner.
        if (hba_xferack || expire || !hba_select) begin
          state_d = StOwned;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs.
  always_comb begin
    hba_mgrant          = (state_q == StIdle) ? 4'b0000 : grant_q;
    hba_xferack_timeout = timeout_q;
    err_valid           = err_valid_q;
    err_overflow        = err_overflow_q;
    err_master          = err_master_q;
    err_addr            = err_addr_q;
  end

  // Ownership bookkeeping.
  always_comb begin
    grant_d = grant_q;
    owner_d = owner_q;
    last_d  = last_q;
    if ((state_q == StIdle) && pick_valid) begin
      grant_d                    = '0;
      grant_d[NUM_MASTERS-1:0]   = pick_gnt;
      owner_d                    = pick_idx;
    end
    if (owner_release) begin
      last_d = owner_q;
    end
  end

  // Watchdog counter runs only while a transfer is still pending; any exit clears it.
  always_comb begin
    cnt_d     = '0;
    timeout_d = expire;
    if ((state_q == StXfer) && hba_select && !hba_xferack && !expire) begin
      cnt_d = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end
  end

  // Error log: the clear is applied first so a coincident capture still lands.
  always_comb begin
    logic valid_base;
    logic ovf_base;
    valid_base     = err_valid_q & ~err_clear;
    ovf_base       = err_overflow_q & ~err_clear;
    err_valid_d    = valid_base;
    err_overflow_d = ovf_base;
    err_master_d   = err_master_q;
    err_addr_d     = err_addr_q;
    if (expire) begin
      if (valid_base) begin
        err_overflow_d = 1'b1;
      end else begin
        err_valid_d  = 1'b1;
        err_master_d = owner_q;
        err_addr_d   = hba_abus;
      end
    end
  end

  always_ff @(posedge hba_clk or negedge hba_reset_n) begin
    if (!hba_reset_n) begin
      grant_q        <= '0;
      owner_q        <= '0;
      last_q         <= LastReset;
      cnt_q          <= '0;
      timeout_q      <= 1'b0;
      err_valid_q    <= 1'b0;
      err_overflow_q <= 1'b0;
      err_master_q   <= '0;
      err_addr_q     <= '0;
    end else begin
      grant_q        <= grant_d;
      owner_q        <= owner_d;
      last_q         <= last_d;
      cnt_q          <= cnt_d;
      timeout_q      <= timeout_d;
      err_valid_q    <= err_valid_d;
      err_overflow_q <= err_overflow_d;
      err_master_q   <= err_master_d;
      err_addr_q     <= err_addr_d;
    end
  end

  grant_onehot_a: assert property (@(posedge hba_clk) disable iff (!hba_reset_n)
    $onehot0(hba_mgrant));

endmodule

// File: tb/tb_hba_bus_ctrl.sv
// Self-checking bench for hba_bus_ctrl: directed scenarios plus randomized ownership
// and transfer traffic checked against a transaction-level model.
module tb_hba_bus_ctrl;

  localparam int unsigned T  = 8;
  localparam int unsigned AW = 12;

  logic          hba_clk;
  logic          hba_reset_n;
  logic [3:0]    hba_mrequest;
  logic          hba_select;
  logic          hba_xferack;
  logic [AW-1:0] hba_abus;
  logic [3:0]    hba_mgrant;
  logic          hba_xferack_timeout;
  logic          err_valid;
  logic          err_overflow;
  logic [1:0]    err_master;
  logic [AW-1:0] err_addr;
  logic          err_clear;

  int n_tests;
  int n_fail;

  // Reference model state
  int            m_last;
  logic          m_valid;
  logic          m_ovf;
  logic [1:0]    m_master;
  logic [AW-1:0] m_addr;

  hba_bus_ctrl #(
    .NUM_MASTERS    (4),
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (T),
    .CNT_WIDTH      (8)
  ) dut (
    .hba_clk             (hba_clk),
    .hba_reset_n         (hba_reset_n),
    .hba_mrequest        (hba_mrequest),
    .hba_select          (hba_select),
    .hba_xferack         (hba_xferack),
    .hba_abus            (hba_abus),
    .hba_mgrant          (hba_mgrant),
    .hba_xferack_timeout (hba_xferack_timeout),
    .err_valid           (err_valid),
    .err_overflow        (err_overflow),
    .err_master          (err_master),
    .err_addr            (err_addr),
    .err_clear           (err_clear)
  );

  initial begin
    hba_clk = 1'b0;
    forever #5 hba_clk = ~hba_clk;
  end

  initial begin
    #500000;
    $display("FAIL time_limit: simulation still running at %0t, required finished", $time);
    $fatal(1, "time limit");
  end

  task automatic step();
    @(posedge hba_clk);
    #1;
  endtask

  // Round-robin rule: first requester after last, wrapping; -1 if none.
  function automatic int rr_next(input logic [3:0] req, input int last);
    for (int k = 1; k <= 4; k++) begin
      int c;
      c = (last + k) % 4;
      if (req[c[1:0]]) return c;
    end
    return -1;
  endfunction

  task automatic m_reset();
    m_last = 3; m_valid = 1'b0; m_ovf = 1'b0; m_master = 2'd0; m_addr = '0;
  endtask

  // Error log rule: clear first, then capture or flag overflow.
  task automatic m_capture(input int master, input logic [AW-1:0] addr, input bit clr);
    if (clr) begin m_valid = 1'b0; m_ovf = 1'b0; end
    if (m_valid) m_ovf = 1'b1;
    else begin m_valid = 1'b1; m_master = 2'(master); m_addr = addr; end
  endtask

  // Drives one transfer from the current owner. Called at #1 after an edge (cycle 0).
  // ack_at: cycle carrying the slave ack; abort_at: cycle select drops (0 = never).
  task automatic run_xfer(input int ack_at, input int abort_at, input logic [AW-1:0] addr,
                          input bit clr_det, output int pulses, output int pcyc,
                          output bit moved);
    logic [3:0] g0;
    bit done;
    pulses = 0; pcyc = -1; moved = 1'b0; done = 1'b0;
    g0 = hba_mgrant;
    hba_select = 1'b1; hba_abus = addr;
    for (int k = 1; k <= int'(T) + 5; k++) begin
      step();
      if (hba_mgrant !== g0) moved = 1'b1;
      if (hba_xferack_timeout === 1'b1) begin
        pulses++;
        if (pcyc < 0) pcyc = k;
      end
      err_clear = clr_det && (k == int'(T));
      if (done) begin
        hba_select = 1'b0; hba_xferack = 1'b0;
      end else if (hba_xferack_timeout === 1'b1 || k == ack_at + 1 || k == abort_at) begin
        done = 1'b1; hba_select = 1'b0; hba_xferack = 1'b0;
      end else if (k == ack_at) begin
        hba_xferack = 1'b1;
      end
    end
    err_clear = 1'b0; hba_abus = '0;
  endtask

  task automatic apply_reset();
    hba_reset_n = 1'b0;
    hba_mrequest = '0; hba_select = 1'b0; hba_xferack = 1'b0; hba_abus = '0; err_clear = 1'b0;
    repeat (2) @(posedge hba_clk);
    @(negedge hba_clk);
    hba_reset_n = 1'b1;
    m_reset();
    step();
  endtask

  task automatic test_reset();
    hba_reset_n = 1'b0;
    hba_mrequest = 4'hF; hba_select = 1'b1; hba_xferack = 1'b0; hba_abus = 12'hFFF;
    err_clear = 1'b0;
    step(); step();
    n_tests++;
    if (hba_mgrant !== 4'b0000 || hba_xferack_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: grant=%b timeout=%b, required 0000/0", hba_mgrant,
               hba_xferack_timeout);
    end
    n_tests++;
    if ({err_valid, err_overflow, err_master, err_addr} !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_err: got %h required 0000",
               {err_valid, err_overflow, err_master, err_addr});
    end
    hba_mrequest = '0; hba_select = 1'b0; hba_abus = '0;
    @(negedge hba_clk);
    hba_reset_n = 1'b1;
    m_reset();
    step();
  endtask

  task automatic test_single();
    int np, pc; bit mv;
    apply_reset();
    hba_mrequest = 4'b0001;
    step();
    n_tests++;
    if (hba_mgrant !== 4'b0001) begin
      n_fail++; $display("FAIL single_grant: got %b required 0001", hba_mgrant);
    end
    run_xfer(3, 0, 12'h155, 1'b0, np, pc, mv);
    n_tests++;
    if (np !== 0 || err_valid !== 1'b0 || mv !== 1'b0) begin
      n_fail++;
      $display("FAIL single_xfer: pulses=%0d err_valid=%b moved=%b, required 0/0/0",
               np, err_valid, mv);
    end
    hba_mrequest = 4'b0000;
    step();
    n_tests++;
    if (hba_mgrant !== 4'b0000) begin
      n_fail++; $display("FAIL single_release: got %b required 0000", hba_mgrant);
    end
    m_last = 0;
    step();
  endtask

  task automatic test_fairness();
    int np, pc, zeros, w, owner;
    bit mv;
    logic [3:0] exp_g;
    apply_reset();
    hba_mrequest = 4'hF;
    for (int i = 0; i < 5; i++) begin
      zeros = 0; w = 0;
      do begin
        step(); w++;
        if (hba_mgrant === 4'b0000) begin zeros++; hba_mrequest = 4'hF; end
      end while (hba_mgrant === 4'b0000 && w < 6);
      owner = rr_next(4'hF, m_last);
      exp_g = 4'b0001 << owner;
      n_tests++;
      if (hba_mgrant !== exp_g || (i > 0 && zeros != 1)) begin
        n_fail++;
        $display("FAIL fair_grant%0d: grant=%b gap=%0d, required %b gap=%0d", i, hba_mgrant,
                 zeros, exp_g, (i > 0) ? 1 : 0);
      end
      run_xfer($urandom_range(1, T), 0, 12'($urandom), 1'b0, np, pc, mv);
      n_tests++;
      if (np != 0 || mv) begin
        n_fail++; $display("FAIL fair_xfer%0d: pulses=%0d moved=%b, required 0/0", i, np, mv);
      end
      hba_mrequest = hba_mrequest & ~exp_g;
      m_last = owner;
    end
    hba_mrequest = 4'b0000;
    step(); step();
  endtask

  task automatic test_timeout();
    int np, pc; bit mv;
    hba_mrequest = 4'b0100;
    step();
    n_tests++;
    if (hba_mgrant !== (4'b0001 << rr_next(4'b0100, m_last))) begin
      n_fail++; $display("FAIL to_grant: got %b required 0100", hba_mgrant);
    end
    run_xfer(999, 0, 12'h6A0, 1'b0, np, pc, mv);
    m_capture(2, 12'h6A0, 1'b0);
    n_tests++;
    if (np != 1 || pc != int'(T) + 1 || mv) begin
      n_fail++;
      $display("FAIL to_pulse: count=%0d cycle=%0d moved=%b, required 1/%0d/0", np, pc, mv,
               T + 1);
    end
    n_tests++;
    if ({err_valid, err_overflow, err_master, err_addr} !== {m_valid, m_ovf, m_master, m_addr})
    begin
      n_fail++;
      $display("FAIL to_err: got %h required %h", {err_valid, err_overflow, err_master, err_addr},
               {m_valid, m_ovf, m_master, m_addr});
    end
    run_xfer(999, 0, 12'h700, 1'b0, np, pc, mv);
    m_capture(2, 12'h700, 1'b0);
    n_tests++;
    if (np != 1 ||
        {err_valid, err_overflow, err_master, err_addr} !== {m_valid, m_ovf, m_master, m_addr})
    begin
      n_fail++;
      $display("FAIL to_overflow: pulses=%0d err=%h required 1/%h", np,
               {err_valid, err_overflow, err_master, err_addr},
               {m_valid, m_ovf, m_master, m_addr});
    end
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    m_valid = 1'b0; m_ovf = 1'b0;
    n_tests++;
    if (err_valid !== 1'b0 || err_overflow !== 1'b0) begin
      n_fail++;
      $display("FAIL to_clear: valid=%b overflow=%b required 0/0", err_valid, err_overflow);
    end
  endtask

  task automatic test_race();
    int np, pc; bit mv;
    run_xfer(T, 0, 12'h0AB, 1'b0, np, pc, mv);
    n_tests++;
    if (np != 0 || err_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL race_ack: pulses=%0d err_valid=%b required 0/0", np, err_valid);
    end
    run_xfer(999, 0, 12'h3C5, 1'b1, np, pc, mv);
    m_capture(2, 12'h3C5, 1'b1);
    n_tests++;
    if ({err_valid, err_overflow, err_master, err_addr} !== {m_valid, m_ovf, m_master, m_addr})
    begin
      n_fail++;
      $display("FAIL race_clear: got %h required %h",
               {err_valid, err_overflow, err_master, err_addr},
               {m_valid, m_ovf, m_master, m_addr});
    end
    hba_mrequest = 4'b0000;
    m_last = 2;
    step(); step();
  endtask

  task automatic test_random();
    int np, pc, owner, nx, ack_at, abort_at;
    bit mv, to, clr;
    logic [3:0] mask, exp_g;
    logic [AW-1:0] addr;
    for (int it = 0; it < 30; it++) begin
      mask = 4'($urandom_range(1, 15));
      hba_mrequest = mask;
      step();
      owner = rr_next(mask, m_last);
      exp_g = 4'b0001 << owner;
      n_tests++;
      if (hba_mgrant !== exp_g) begin
        n_fail++;
        $display("FAIL rnd_grant%0d: req=%b last=%0d got %b required %b", it, mask, m_last,
                 hba_mgrant, exp_g);
      end
      nx = $urandom_range(1, 2);
      for (int j = 0; j < nx; j++) begin
        if ($urandom_range(0, 3) == 0) begin
          abort_at = $urandom_range(1, T - 1); ack_at = 999;
        end else begin
          abort_at = 0; ack_at = $urandom_range(1, T + 3);
        end
        addr = AW'($urandom);
        to   = (abort_at == 0) && (ack_at > int'(T));
        clr  = to && ($urandom_range(0, 3) == 0);
        run_xfer(ack_at, abort_at, addr, clr, np, pc, mv);
        if (to) m_capture(owner, addr, clr);
        n_tests++;
        if (np != (to ? 1 : 0) || (to && pc != int'(T) + 1) || mv) begin
          n_fail++;
          $display("FAIL rnd_xfer%0d.%0d: ack=%0d abort=%0d pulses=%0d cycle=%0d moved=%b",
                   it, j, ack_at, abort_at, np, pc, mv);
        end
        n_tests++;
        if ({err_valid, err_overflow, err_master, err_addr} !==
            {m_valid, m_ovf, m_master, m_addr}) begin
          n_fail++;
          $display("FAIL rnd_err%0d.%0d: got %h required %h", it, j,
                   {err_valid, err_overflow, err_master, err_addr},
                   {m_valid, m_ovf, m_master, m_addr});
        end
      end
      if ($urandom_range(0, 3) == 0) begin
        err_clear = 1'b1;
        step();
        err_clear = 1'b0;
        m_valid = 1'b0; m_ovf = 1'b0;
      end
      hba_mrequest = 4'b0000;
      step();
      n_tests++;
      if (hba_mgrant !== 4'b0000) begin
        n_fail++; $display("FAIL rnd_release%0d: got %b required 0000", it, hba_mgrant);
      end
      m_last = owner;
    end
  endtask

  task automatic test_reset_mid();
    hba_mrequest = 4'b0010;
    step();
    n_tests++;
    if (hba_mgrant !== 4'b0010) begin
      n_fail++; $display("FAIL mid_grant: got %b required 0010", hba_mgrant);
    end
    hba_select = 1'b1; hba_abus = 12'h2B4;
    repeat (T + 1) step();
    n_tests++;
    if (hba_xferack_timeout !== 1'b1 || err_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: timeout=%b err_valid=%b required 1/1", hba_xferack_timeout,
               err_valid);
    end
    #2;
    hba_reset_n = 1'b0;
    #1;
    n_tests++;
    if (hba_mgrant !== 4'b0000 || hba_xferack_timeout !== 1'b0 || err_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_async: grant=%b timeout=%b err_valid=%b required 0000/0/0",
               hba_mgrant, hba_xferack_timeout, err_valid);
    end
    hba_select = 1'b0; hba_abus = '0; hba_mrequest = 4'b0000;
    @(negedge hba_clk);
    hba_reset_n = 1'b1;
    m_reset();
    step();
    hba_mrequest = 4'b1010;
    step();
    n_tests++;
    if (hba_mgrant !== (4'b0001 << rr_next(4'b1010, m_last))) begin
      n_fail++; $display("FAIL mid_first: got %b required 0010", hba_mgrant);
    end
    hba_mrequest = 4'b0000;
    step(); step();
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_reset();
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_race();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hba_bus_ctrl.md
Name: hba_bus_ctrl

Overview:
- Round-robin bus controller for the HBA bus.
- Shares the bus among up to 4 masters using the hba_mrequest/hba_mgrant handshake.
- Supervises every granted transfer with a watchdog. If no slave acknowledges in time, the block generates a synthetic transfer acknowledge so the master cannot hang on an unmapped or dead slot, and latches error status.
- Drop-in replacement for the single-priority arbiter. The system ORs hba_xferack_timeout into the slave xferack OR-tree.

Parameters:
- NUM_MASTERS, 4, number of requesters (1..4); unused request bits are ignored.
- ADDR_WIDTH, 12, HBA address bus width (PERIPH_ADDR_WIDTH + REG_ADDR_WIDTH).
- TIMEOUT_CYCLES, 255, cycles hba_select may stay high without hba_xferack before a timeout fires; 0 disables the watchdog.
- CNT_WIDTH, 8, width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- hba_clk  in  1  bus clock.
- hba_reset_n  in  1  asynchronous, active-low reset.
- hba_mrequest  in  4  per-master bus request; held high for the whole ownership period.
- hba_select  in  1  OR'd master select; a transfer is in progress.
- hba_xferack  in  1  OR'd slave acknowledge.
- hba_abus  in  ADDR_WIDTH  OR'd address bus; captured on error.
- hba_mgrant  out  4  one-hot grant, or zero.
- hba_xferack_timeout  out  1  one-cycle synthetic acknowledge on watchdog expiry.
- err_valid  out  1  sticky: a timeout has occurred.
- err_overflow  out  1  sticky: another timeout occurred while err_valid was already set.
- err_master  out  2  index of the master that owned the timed-out transfer.
- err_addr  out  ADDR_WIDTH  hba_abus sampled at the timeout.
- err_clear  in  1  one-cycle pulse; clears err_valid and err_overflow.

Behaviour:
- Reset: asynchronous, active-low. While reset is asserted, all outputs are 0, the FSM is in IDLE, the watchdog counter is 0, and last_grant = NUM_MASTERS-1, so master 0 has first priority.
- Reset mid-transfer: grant and timeout outputs drop immediately; error state is lost.
- FSM states:
  - IDLE
    - hba_mgrant = 0.
    - If any enabled request is high, select the first requester scanning from last_grant+1 with wrap-around, e.g. last=2 scans 3,0,1,2.
    - Register the one-hot grant and go to OWNED. Latency is 1 cycle from request to grant.
  - OWNED
    - The grant is held.
    - If hba_select=1, go to XFER. The counter is 0 on entry and increments each XFER cycle.
    - Else, if the owner's request=0, go to IDLE, set last_grant = owner, and drop the grant the next cycle. This gives a mandatory 1-cycle turnaround with no grant between owners.
    - Requests from other masters are ignored while OWNED (no preemption).
  - XFER
    - The grant is held regardless of the owner's request.
    - If hba_xferack=1, clear the counter and go to OWNED.
    - Else, if TIMEOUT_CYCLES!=0 and the counter equals TIMEOUT_CYCLES-1, do all of the following:
      - pulse hba_xferack_timeout for exactly 1 cycle (registered; asserted the cycle after detection);
      - capture err_master = owner and err_addr = hba_abus in the detection cycle;
      - set err_valid, or set err_overflow if err_valid is already 1, in which case err_master/err_addr are not updated (first error is kept);
      - clear the counter and go to OWNED.
    - Else, if hba_select drops without an ack (master abort), go to OWNED with no error.
- Simultaneous events:
  - xferack in the same cycle as counter expiry: the real ack wins; no pulse, no error.
  - err_clear in the same cycle as a new error capture: the capture wins; err_valid=1, err_overflow=0.
- Counter: saturating-safe; it never wraps because it clears on ack, on timeout, and on exit from XFER.
- Requests on masters with index >= NUM_MASTERS are masked to 0.
- hba_mgrant is always one-hot or zero; it never changes while hba_select=1.

Decomposition:
- Shared package hba_pkg holds:
  - the state encoding (IDLE, OWNED, XFER);
  - the default NUM_MASTERS/ADDR_WIDTH/TIMEOUT_CYCLES constants;
  - the master-index width.
- One sub-module, hba_rr_pick: combinational round-robin picker (request vector + last index → one-hot + index), reusable by future interrupt-vector arbitration. The watchdog and error registers stay inline.

Test Plan:
- Single master: req[0]=1 after reset → mgrant=0001 one cycle later; select pulse with ack at 3 cycles → no timeout, err_valid=0; drop req → mgrant=0000 next cycle.
- Fairness: req=1111 held, each owner does 1 ack'd transfer then drops/re-raises its request → grant order 0,1,2,3,0, each separated by exactly 1 zero-grant cycle.
- Timeout: TIMEOUT_CYCLES=8, master 2 selects abus=0x6A0 with no slave → hba_xferack_timeout high for exactly 1 cycle, 9 cycles after select rises; err_valid=1, err_master=2, err_addr=0x6A0; grant stays 0100.
- Second timeout: with err_valid still set, a second timeout at abus=0x700 → err_overflow=1, err_addr stays 0x6A0; err_clear → both flags 0.
- Race: ack arrives exactly on the expiry cycle → no pulse, err_valid=0. A separate error capture coincident with err_clear → err_valid=1.
- Reset mid-XFER: hba_reset_n low while master 1 owns the bus → mgrant=0000 and timeout=0 asynchronously; after release, req=0010 → master 1 is granted first (last_grant reset value = 3).
